pipe_stage_regs: RTL and testbench
==================================

# pipe_stage_regs

Fetch-to-Execute pipeline register bank for the five-stage MIPS core: the PC register, the F/D register and the D/E register. It applies the stall and flush controls raised by the hazard logic. It holds state on stalls, inserts NOP bubbles on flushes, and tracks a per-stage valid bit so later stages can tell real instructions from bubbles. An optional performance-counter set counts stall and bubble cycles.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `CTRL_W`, default 16: width of the decoded control bundle carried from D to E.
- `clk`  in  1: core clock; every register updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `StallF`  in  1: hold the PC register.
- `StallD`  in  1: hold the F/D register.
- `FlushD`  in  1: clear the F/D register (taken branch or jump resolved in D).
- `FlushE`  in  1: clear the D/E register (insert a bubble).
- `PCNextF`  in  32: next PC from the PC mux.
- `InstrF`  in  32: fetched instruction.
- `PCPlus4F`  in  32: PCF+4.
- `PCF`  out  32: current fetch PC.
- `InstrD`, `PCPlus4D`  out  32 each: F/D contents.
- `ValidD`  out  1: F/D holds a real instruction.
- `CtrlD`  in  CTRL_W: decoded control.
- `RD1D`, `RD2D`, `SignImmD`  in  32 each: register-file reads and the sign-extended immediate.
- `rsD`, `rtD`, `rdD`  in  5 each: register specifiers.
- `CtrlE`, `RD1E`, `RD2E`, `SignImmE`, `rsE`, `rtE`, `rdE`  out: D/E contents, same widths as their D-side inputs.
- `ValidE`  out  1: D/E holds a real instruction.
- `StallCnt`, `BubbleCnt`, `FlushDCnt`  out  32 each: performance counters (see Configuration).

## Operation
- **PC register priority, highest first:**
  - reset: PCF=RESET_PC.
  - StallF: hold.
  - otherwise: load PCNextF.
- **F/D register priority, highest first:**
  - reset: clear.
  - StallD: hold, including ValidD.
  - FlushD: InstrD=0 (sll $0,$0,0 = NOP), PCPlus4D=0, ValidD=0.
  - otherwise: load InstrF and PCPlus4F, ValidD=1.
- **StallD and FlushD together:** StallD wins, because the branch in D is still unresolved. FlushD is recorded only when StallD is low.
- **D/E register priority, highest first:**
  - reset: clear.
  - FlushE: all fields 0, ValidE=0.
  - otherwise: load all D-side inputs, ValidE=ValidD.
- **No stall input for E.** E advances every cycle. A stall in D therefore requires FlushE from the hazard unit; this block does not infer it.
- **Zero bubble:** CtrlE=0 must decode as no regwrite, no memwrite, no branch. rdE=0 and rtE=0, so forwarding never matches a bubble.
- **StallF without StallD:** legal. PC holds while F/D reloads the same InstrF; no special handling.
- **Reset values:** PCF=RESET_PC; every other output 0, including ValidD, ValidE and all counters.

## Timing
- **Latency:** one cycle per stage. A value present on a D-side input at edge n appears on the E output after edge n.
- **Control timing:** stall and flush inputs are sampled at the rising edge and act on that edge. They are combinational from the current cycle; no registering inside this block.
- **Reset:** asynchronous assertion. Outputs go to reset values without a clock edge. Deassertion is synchronous to clk (synchronized externally). The first edge with reset low loads PCNextF.
- **Reset mid-stall:** reset overrides everything; all stall history and counters clear.
- **Pipeline fill after reset:** ValidD=0 and ValidE=0 until real instructions propagate, i.e. 1 edge for ValidD and 2 edges for ValidE.

## Configuration
- **Macro:** `PIPE_PERF_CNT_EN`.
- **Defined:** three 32-bit counters, each cleared by reset.
  - StallCnt: +1 every edge with StallF=1.
  - BubbleCnt: +1 every edge with FlushE=1.
  - FlushDCnt: +1 every edge with FlushD=1 and StallD=0.
  - All three saturate at 32'hFFFF_FFFF; no wrap.
- **Not defined:** the counter logic is absent; StallCnt, BubbleCnt and FlushDCnt are tied to 0. The ports remain so the top level is unchanged.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle with RESET_PC=32'h0040_0000 -> PCF=32'h0040_0000 before the next edge; ValidD=ValidE=0; counters 0.
- **Free run:** no stalls, PCNextF=PCF+4, InstrF=32'h8C08_0004 -> InstrD=32'h8C08_0004 after 1 edge with ValidD=1; ValidE=1 after 2 edges.
- **Load-use stall:** StallF=StallD=FlushE=1 for one edge -> PCF and InstrD unchanged; ValidE=0 and CtrlE=0 with rdE=0; StallCnt=1 and BubbleCnt=1 (macro on).
- **Taken branch:** FlushD=1, StallD=0 -> InstrD=0 and ValidD=0; the next edge gives ValidE=0. With StallD=1 as well -> InstrD held and FlushDCnt unchanged.
- **Saturation:** force StallCnt to 32'hFFFF_FFFE, hold StallF=1 for 3 edges -> StallCnt ends at 32'hFFFF_FFFF.
- **Macro off:** repeat the load-use scenario without `PIPE_PERF_CNT_EN` -> all counters read 0; pipeline behaviour identical.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// PC, F/D and D/E pipeline registers applying hazard-unit stall/flush controls; one cycle per stage.
// Optional stall/bubble/flush counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       SignImmD,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        rdD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       SignImmE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
    output logic              ValidE,
    output logic [31:0]       StallCnt,
    output logic [31:0]       BubbleCnt,
    output logic [31:0]       FlushDCnt
);

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_d_q, instr_d_d;
    logic [31:0]       pcplus4_d_q, pcplus4_d_d;
    logic              valid_d_q, valid_d_d;
    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    logic [31:0]       rd1_e_q, rd1_e_d;
    logic [31:0]       rd2_e_q, rd2_e_d;
    logic [31:0]       imm_e_q, imm_e_d;
    logic [4:0]        rs_e_q, rs_e_d;
    logic [4:0]        rt_e_q, rt_e_d;
    logic [4:0]        rd_e_q, rd_e_d;
    logic              valid_e_q, valid_e_d;

    always_comb begin
        pc_d        = pc_q;
        instr_d_d   = instr_d_q;
        pcplus4_d_d = pcplus4_d_q;
        valid_d_d   = valid_d_q;
        if (!StallF) begin
            pc_d = PCNextF;
        end
        // A stalled D keeps its branch, so a flush is only honoured when D moves.
        if (!StallD) begin
            if (FlushD) begin
                instr_d_d   = 32'h0;
                pcplus4_d_d = 32'h0;
                valid_d_d   = 1'b0;
            end else begin
                instr_d_d   = InstrF;
                pcplus4_d_d = PCPlus4F;
                valid_d_d   = 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_e_d  = CtrlD;
        rd1_e_d   = RD1D;
        rd2_e_d   = RD2D;
        imm_e_d   = SignImmD;
        rs_e_d    = rsD;
        rt_e_d    = rtD;
        rd_e_d    = rdD;
        valid_e_d = valid_d_q;
        // All-zero bubble: no writes, and zero specifiers never match forwarding.
        if (FlushE) begin
            ctrl_e_d  = '0;
            rd1_e_d   = 32'h0;
            rd2_e_d   = 32'h0;
            imm_e_d   = 32'h0;
            rs_e_d    = 5'd0;
            rt_e_d    = 5'd0;
            rd_e_d    = 5'd0;
            valid_e_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_d_q   <= 32'h0;
            pcplus4_d_q <= 32'h0;
            valid_d_q   <= 1'b0;
            ctrl_e_q    <= '0;
            rd1_e_q     <= 32'h0;
            rd2_e_q     <= 32'h0;
            imm_e_q     <= 32'h0;
            rs_e_q      <= 5'd0;
            rt_e_q      <= 5'd0;
            rd_e_q      <= 5'd0;
            valid_e_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_d_q   <= instr_d_d;
            pcplus4_d_q <= pcplus4_d_d;
            valid_d_q   <= valid_d_d;
            ctrl_e_q    <= ctrl_e_d;
            rd1_e_q     <= rd1_e_d;
            rd2_e_q     <= rd2_e_d;
            imm_e_q     <= imm_e_d;
            rs_e_q      <= rs_e_d;
            rt_e_q      <= rt_e_d;
            rd_e_q      <= rd_e_d;
            valid_e_q   <= valid_e_d;
        end
    end

    assign PCF      = pc_q;
    assign InstrD   = instr_d_q;
    assign PCPlus4D = pcplus4_d_q;
    assign ValidD   = valid_d_q;
    assign CtrlE    = ctrl_e_q;
    assign RD1E     = rd1_e_q;
    assign RD2E     = rd2_e_q;
    assign SignImmE = imm_e_q;
    assign rsE      = rs_e_q;
    assign rtE      = rt_e_q;
    assign rdE      = rd_e_q;
    assign ValidE   = valid_e_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flushd_cnt_q, flushd_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flushd_cnt_d = flushd_cnt_q;
        if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (FlushE && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (FlushD && !StallD && (flushd_cnt_q != 32'hFFFF_FFFF)) begin
            flushd_cnt_d = flushd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
            flushd_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flushd_cnt_q <= flushd_cnt_d;
        end
    end

    assign StallCnt  = stall_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
    assign FlushDCnt = flushd_cnt_q;
`else
    assign StallCnt  = 32'h0;
    assign BubbleCnt = 32'h0;
    assign FlushDCnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: directed hazard scenarios then random controls against a rule-level model.
module tb_pipe_stage_regs;

    localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, FlushE;
    logic [31:0] PCNextF, InstrF, PCPlus4F, PCF, InstrD, PCPlus4D;
    logic        ValidD, ValidE;
    logic [15:0] CtrlD, CtrlE;
    logic [31:0] RD1D, RD2D, SignImmD, RD1E, RD2E, SignImmE;
    logic [4:0]  rsD, rtD, rdD, rsE, rtE, rdE;
    logic [31:0] StallCnt, BubbleCnt, FlushDCnt;

    pipe_stage_regs #(.RESET_PC(RPC), .CTRL_W(16)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .PCNextF(PCNextF), .InstrF(InstrF),
        .PCPlus4F(PCPlus4F), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D),
        .SignImmD(SignImmD), .rsD(rsD), .rtD(rtD), .rdD(rdD), .CtrlE(CtrlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .rsE(rsE), .rtE(rtE),
        .rdE(rdE), .ValidE(ValidE), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt),
        .FlushDCnt(FlushDCnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: what each stage should hold after the edges applied so far.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_vd, m_ve;
    logic [31:0] m_e [7];   // ctrl, rd1, rd2, imm, rs, rt, rd
    logic [31:0] m_stall, m_bubble, m_flushd;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_instr = 0; m_pc4 = 0; m_vd = 0; m_ve = 0;
        for (int i = 0; i < 7; i++) m_e[i] = 0;
        m_stall = 0; m_bubble = 0; m_flushd = 0;
    endtask

    // Applies one rising edge's worth of rules to the model, using the inputs now on the pins.
    task automatic model_edge();
        if (FlushE) begin
            for (int i = 0; i < 7; i++) m_e[i] = 0;
            m_ve = 0;
        end else begin
            m_e[0] = {16'h0, CtrlD}; m_e[1] = RD1D; m_e[2] = RD2D; m_e[3] = SignImmD;
            m_e[4] = {27'h0, rsD}; m_e[5] = {27'h0, rtD}; m_e[6] = {27'h0, rdD};
            m_ve = m_vd;
        end
        if (!StallD && FlushD) begin
            m_instr = 0; m_pc4 = 0; m_vd = 0;
        end else if (!StallD) begin
            m_instr = InstrF; m_pc4 = PCPlus4F; m_vd = 1;
        end
        if (!StallF) m_pc = PCNextF;
        if (StallF) m_stall = sat_inc(m_stall);
        if (FlushE) m_bubble = sat_inc(m_bubble);
        if (FlushD && !StallD) m_flushd = sat_inc(m_flushd);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".PCF"}, PCF, m_pc);
        chk({ph, ".InstrD"}, InstrD, m_instr);
        chk({ph, ".PCPlus4D"}, PCPlus4D, m_pc4);
        chk({ph, ".ValidD"}, {31'h0, ValidD}, {31'h0, m_vd});
        chk({ph, ".CtrlE"}, {16'h0, CtrlE}, m_e[0]);
        chk({ph, ".RD1E"}, RD1E, m_e[1]);
        chk({ph, ".RD2E"}, RD2E, m_e[2]);
        chk({ph, ".SignImmE"}, SignImmE, m_e[3]);
        chk({ph, ".rsE"}, {27'h0, rsE}, m_e[4]);
        chk({ph, ".rtE"}, {27'h0, rtE}, m_e[5]);
        chk({ph, ".rdE"}, {27'h0, rdE}, m_e[6]);
        chk({ph, ".ValidE"}, {31'h0, ValidE}, {31'h0, m_ve});
        chk({ph, ".StallCnt"}, StallCnt, PERF ? m_stall : 32'h0);
        chk({ph, ".BubbleCnt"}, BubbleCnt, PERF ? m_bubble : 32'h0);
        chk({ph, ".FlushDCnt"}, FlushDCnt, PERF ? m_flushd : 32'h0);
    endtask

    task automatic step(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic set_ctrl(input logic sf, input logic sd, input logic fd, input logic fe);
        StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
    endtask

    task automatic rand_dside();
        CtrlD = 16'($urandom); RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
        rsD = 5'($urandom); rtD = 5'($urandom); rdD = 5'($urandom);
    endtask

    task automatic seq_fetch();
        PCNextF = m_pc + 32'd4; PCPlus4F = m_pc + 32'd4;
    endtask

    initial begin
        reset = 1'b1;
        set_ctrl(0, 0, 0, 0);
        PCNextF = 0; InstrF = 0; PCPlus4F = 0;
        CtrlD = 0; RD1D = 0; RD2D = 0; SignImmD = 0; rsD = 0; rtD = 0; rdD = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Free run with a fixed lw instruction.
        InstrF = 32'h8C08_0004;
        seq_fetch(); rand_dside();
        step("fill1");
        chk("fill1.InstrD_lit", InstrD, 32'h8C08_0004);
        chk("fill1.ValidE_lit", {31'h0, ValidE}, 32'h0);
        seq_fetch(); rand_dside();
        step("fill2");
        chk("fill2.ValidE_lit", {31'h0, ValidE}, 32'h1);

        // Load-use: hold F and D, bubble into E.
        set_ctrl(1, 1, 0, 1);
        InstrF = 32'h0123_4567; seq_fetch(); rand_dside();
        step("loaduse");
        chk("loaduse.rdE_lit", {27'h0, rdE}, 32'h0);
        chk("loaduse.StallCnt_lit", StallCnt, PERF ? 32'd1 : 32'd0);
        chk("loaduse.BubbleCnt_lit", BubbleCnt, PERF ? 32'd1 : 32'd0);

        // Taken branch resolved in D.
        set_ctrl(0, 0, 1, 0);
        seq_fetch(); rand_dside();
        step("branch");
        chk("branch.InstrD_lit", InstrD, 32'h0);
        set_ctrl(0, 0, 0, 0);
        InstrF = 32'h2008_0001; seq_fetch(); rand_dside();
        step("branch_next");
        chk("branch_next.ValidE_lit", {31'h0, ValidE}, 32'h0);
        // Flush while stalled: stall wins.
        set_ctrl(1, 1, 1, 1);
        InstrF = 32'hDEAD_BEEF; seq_fetch(); rand_dside();
        step("flush_stalled");
        chk("flush_stalled.InstrD_lit", InstrD, 32'h2008_0001);
        chk("flush_stalled.FlushDCnt_lit", FlushDCnt, PERF ? 32'd1 : 32'd0);

`ifdef PIPE_PERF_CNT_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFE;
        set_ctrl(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            seq_fetch(); rand_dside();
            step("sat");
        end
        chk("sat.StallCnt_lit", StallCnt, 32'hFFFF_FFFF);
`endif

        // Random control and data traffic.
        for (int n = 0; n < 300; n++) begin
            set_ctrl($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
            InstrF = $urandom; PCNextF = $urandom; PCPlus4F = $urandom; rand_dside();
            step("rand");
        end

        // Asynchronous reset mid-cycle, after state has built up.
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset = 1'b0;
        set_ctrl(0, 0, 0, 0);
        InstrF = 32'h8C08_0004; seq_fetch(); rand_dside();
        step("post_rst");
        chk("post_rst.PCF_lit", PCF, RPC + 32'd4);
        step("post_rst2");
        chk("post_rst2.ValidE_lit", {31'h0, ValidE}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
